// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: walks each instruction through fetch/decode/execute/memory/write-back
// sharing one ALU and one memory port, stalling on the memory ready handshake.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_t state_q, state_d;

  logic mem_read, mem_write, ir_write, reg_write, pc_en, illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    IorD       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    reg_write  = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    pc_en      = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_read   = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        ir_write   = MemReady;
        pc_en      = MemReady;
        state_d    = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (OpCode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_d    = (OpCode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
        state_d  = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        // Write strobe is held until memory accepts it.
        IorD      = 1'b1;
        mem_write = 1'b1;
        state_d   = MemReady ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        state_d = ALUWB;
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        pc_en      = Zero;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_d    = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        pc_en = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Strobes are masked during reset since FETCH would otherwise follow MemReady.
  assign MemRead  = mem_read  & rst_n;
  assign MemWrite = mem_write & rst_n;
  assign IRWrite  = ir_write  & rst_n;
  assign RegWrite = reg_write & rst_n;
  assign PCEn     = pc_en     & rst_n;
  assign Illegal  = illegal   & rst_n;
  assign State    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks every instruction class, stalls and resets.
module tb_mc_control_fsm;
  logic       clk;
  logic       rst_n;
  logic [5:0] OpCode, Funct;
  logic       Zero, MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, Illegal;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .PCEn(PCEn), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [5:0] funct_tab [6];
  logic [2:0] aluc_tab  [6];

  initial begin
    funct_tab[0] = 6'b100000; aluc_tab[0] = 3'b010;
    funct_tab[1] = 6'b100010; aluc_tab[1] = 3'b110;
    funct_tab[2] = 6'b100100; aluc_tab[2] = 3'b000;
    funct_tab[3] = 6'b100101; aluc_tab[3] = 3'b001;
    funct_tab[4] = 6'b101010; aluc_tab[4] = 3'b111;
    funct_tab[5] = 6'b111111; aluc_tab[5] = 3'b010;

    rst_n = 1'b0; MemReady = 1'b1; OpCode = 6'd0; Funct = 6'd0; Zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", State, 0);
    chk("rst_pcen", PCEn, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_alusrcb", ALUSrcB, 2'b01);
    chk("rst_aluctl", ALUControl, 3'b010);
    rst_n = 1'b1;
    #1;
    chk("rel_irwrite", IRWrite, 1);
    chk("rel_pcen", PCEn, 1);
    chk("rel_memread", MemRead, 1);

    // lw, no stalls
    OpCode = 6'b100011;
    tick(); chk("lw_s1", State, 1); chk("lw_dec_srcb", ALUSrcB, 2'b11); chk("lw_dec_irw", IRWrite, 0);
    tick(); chk("lw_s2", State, 2); chk("lw_adr_srca", ALUSrcA, 1); chk("lw_adr_srcb", ALUSrcB, 2'b10);
    tick(); chk("lw_s3", State, 3); chk("lw_rd_iord", IorD, 1); chk("lw_rd_memread", MemRead, 1);
    chk("lw_rd_regwrite", RegWrite, 0);
    tick(); chk("lw_s4", State, 4); chk("lw_wb_regwrite", RegWrite, 1);
    chk("lw_wb_memtoreg", MemtoReg, 1); chk("lw_wb_regdst", RegDst, 0);
    tick(); chk("lw_s0", State, 0); chk("lw_end_regwrite", RegWrite, 0);

    // sw with two stall cycles in MEMWR
    OpCode = 6'b101011;
    tick(); chk("sw_s1", State, 1);
    tick(); chk("sw_s2", State, 2);
    tick(); chk("sw_s5a", State, 5); chk("sw_mw1", MemWrite, 1); chk("sw_iord", IorD, 1);
    chk("sw_rw1", RegWrite, 0);
    MemReady = 1'b0;
    tick(); chk("sw_s5b", State, 5); chk("sw_mw2", MemWrite, 1); chk("sw_rw2", RegWrite, 0);
    tick(); chk("sw_s5c", State, 5); chk("sw_mw3", MemWrite, 1); chk("sw_rw3", RegWrite, 0);
    MemReady = 1'b1;
    tick(); chk("sw_s0", State, 0); chk("sw_mw_end", MemWrite, 0);

    // R-type with each Funct, plus an unknown Funct
    OpCode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      Funct = funct_tab[i];
      tick(); chk("r_s1", State, 1);
      tick(); chk("r_s6", State, 6); chk("r_aluctl", ALUControl, aluc_tab[i]);
      chk("r_srca", ALUSrcA, 1); chk("r_srcb", ALUSrcB, 2'b00); chk("r_illegal", Illegal, 0);
      tick(); chk("r_s7", State, 7); chk("r_regwrite", RegWrite, 1); chk("r_regdst", RegDst, 1);
      chk("r_memtoreg", MemtoReg, 0);
      tick(); chk("r_s0", State, 0);
    end

    // addi
    OpCode = 6'b001000;
    tick(); chk("addi_s1", State, 1);
    tick(); chk("addi_s9", State, 9); chk("addi_srcb", ALUSrcB, 2'b10); chk("addi_aluctl", ALUControl, 3'b010);
    tick(); chk("addi_s10", State, 10); chk("addi_regwrite", RegWrite, 1); chk("addi_regdst", RegDst, 0);
    tick(); chk("addi_s0", State, 0);

    // beq taken
    OpCode = 6'b000100; Zero = 1'b1;
    tick(); chk("beqt_s1", State, 1);
    tick(); chk("beqt_s8", State, 8); chk("beqt_pcen", PCEn, 1); chk("beqt_pcsrc", PCSrc, 2'b01);
    chk("beqt_aluctl", ALUControl, 3'b110);
    tick(); chk("beqt_s0", State, 0);

    // beq not taken
    Zero = 1'b0;
    tick(); chk("beqn_s1", State, 1);
    tick(); chk("beqn_s8", State, 8); chk("beqn_pcen", PCEn, 0);
    tick(); chk("beqn_s0", State, 0);

    // j
    OpCode = 6'b000010;
    tick(); chk("j_s1", State, 1);
    tick(); chk("j_s11", State, 11); chk("j_pcen", PCEn, 1); chk("j_pcsrc", PCSrc, 2'b10);
    tick(); chk("j_s0", State, 0);

    // illegal opcode
    OpCode = 6'b111111;
    chk("ill_fetch", Illegal, 0);
    tick(); chk("ill_s1", State, 1); chk("ill_pulse", Illegal, 1);
    tick(); chk("ill_s0", State, 0); chk("ill_clear", Illegal, 0);

    // FETCH stall
    MemReady = 1'b0;
    #1;
    chk("fst_irwrite", IRWrite, 0); chk("fst_pcen", PCEn, 0);
    tick(); chk("fst_hold", State, 0);
    MemReady = 1'b1;

    // reset asserted during MEMRD
    OpCode = 6'b100011;
    tick(); chk("mr_s1", State, 1);
    tick(); chk("mr_s2", State, 2);
    tick(); chk("mr_s3", State, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_rst_state", State, 0); chk("mr_rst_memread", MemRead, 0); chk("mr_rst_regwrite", RegWrite, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_rel_state", State, 0); chk("mr_rel_regwrite", RegWrite, 0);
    tick(); chk("mr_restart", State, 1); chk("mr_restart_rw", RegWrite, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
